// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: collects 16 real audio samples into a complex frame, starts a
// 16-point FFT core, waits for its result with a timeout, and drains the 16
// result bins one by one over a valid/ready handshake.
//
// Optional feature: define FFT_BITREV_EN to place sample n in slot bitrev4(n),
// which hands a decimation-in-time core its input already bit-reversed.
// Without the macro, sample n goes to slot n.
module fft_frame_ctrl #(
  parameter int DONE_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [17:0]  sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic [575:0] fft_in,
  output logic         fft_start,
  input  logic [575:0] fft_out,
  input  logic         fft_done,
  output logic [35:0]  bin_out,
  output logic [3:0]   bin_idx,
  output logic         bin_valid,
  input  logic         bin_ready,
  output logic         bin_last,
  output logic         fft_timeout
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(DONE_TIMEOUT);

  state_t      state;
  state_t      next_state;

  logic [3:0]  fill_cnt;
  logic [3:0]  bin_cnt;
  logic [3:0]  slot_sel;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_inc;
  logic [35:0] slot_q   [16];
  logic [35:0] buffer_q [16];
  logic        timeout_q;

  logic        sample_take;
  logic        last_sample;
  logic        done_take;
  logic        abort;
  logic        bin_take;
  logic        last_bin;

  assign wait_cnt_inc = wait_cnt + 8'd1;

`ifdef FFT_BITREV_EN
  assign slot_sel = {fill_cnt[0], fill_cnt[1], fill_cnt[2], fill_cnt[3]};
`else
  assign slot_sel = fill_cnt;
`endif

  // State register; reset always lands in FILL so a partial frame is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the per-cycle event strobes that steer the datapath.
  always_comb begin
    next_state  = state;
    sample_take = 1'b0;
    last_sample = 1'b0;
    done_take   = 1'b0;
    abort       = 1'b0;
    bin_take    = 1'b0;
    last_bin    = 1'b0;
    case (state)
      FILL: begin
        sample_take = sample_valid;
        if (sample_valid && (fill_cnt == 4'd15)) begin
          last_sample = 1'b1;
          next_state  = WAIT;
        end
      end
      WAIT: begin
        if (fft_done) begin
          done_take  = 1'b1;
          next_state = DRAIN;
        end else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
          abort      = 1'b1;
          next_state = FILL;
        end
      end
      DRAIN: begin
        bin_take = bin_ready;
        if (bin_ready && (bin_cnt == 4'd15)) begin
          last_bin   = 1'b1;
          next_state = FILL;
        end
      end
      default: begin
        next_state = FILL;
      end
    endcase
  end

  // Counters, the sticky timeout flag, and the input slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt  <= '0;
      wait_cnt  <= '0;
      bin_cnt   <= '0;
      timeout_q <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      if (sample_take) begin
        slot_q[slot_sel] <= {sample_in, 18'd0};
        fill_cnt         <= fill_cnt + 4'd1;
      end
      if (abort || last_bin) begin
        fill_cnt <= '0;
      end
      if (last_sample) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt_inc;
      end
      if (bin_take) begin
        bin_cnt <= bin_cnt + 4'd1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Snapshot of the FFT result, taken once because fft_out is only valid with fft_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        buffer_q[k] <= '0;
      end
    end else if (done_take) begin
      for (int k = 0; k < 16; k++) begin
        buffer_q[k] <= fft_out[36*k +: 36];
      end
    end
  end

  // Moore outputs, forced to zero for as long as reset is held.
  always_comb begin
    sample_ready = 1'b0;
    fft_start    = 1'b0;
    bin_valid    = 1'b0;
    bin_out      = '0;
    bin_idx      = '0;
    bin_last     = 1'b0;
    fft_timeout  = 1'b0;
    fft_in       = '0;
    if (!reset) begin
      sample_ready = (state == FILL);
      fft_start    = (state == WAIT);
      bin_valid    = (state == DRAIN);
      bin_idx      = bin_cnt;
      bin_out      = buffer_q[bin_cnt];
      bin_last     = (state == DRAIN) && (bin_cnt == 4'd15);
      fft_timeout  = timeout_q;
      for (int k = 0; k < 16; k++) begin
        fft_in[36*k +: 36] = slot_q[k];
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl. Expected slot placement
// follows FFT_BITREV_EN the same way the design does, so the bench is built
// with the same macro setting as the RTL.
module tb_fft_frame_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [17:0]  sample_in;
  logic         sample_valid;
  logic         sample_ready;
  logic [575:0] fft_in;
  logic         fft_start;
  logic [575:0] fft_out;
  logic         fft_done;
  logic [35:0]  bin_out;
  logic [3:0]   bin_idx;
  logic         bin_valid;
  logic         bin_ready;
  logic         bin_last;
  logic         fft_timeout;

  int checks   = 0;
  int failures = 0;

  fft_frame_ctrl #(.DONE_TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fft_in       (fft_in),
    .fft_start    (fft_start),
    .fft_out      (fft_out),
    .fft_done     (fft_done),
    .bin_out      (bin_out),
    .bin_idx      (bin_idx),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bin_last     (bin_last),
    .fft_timeout  (fft_timeout)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Expected content of input slot k when sample n carried value base+n.
  function automatic logic [35:0] exp_slot(input int base, input int k);
    logic [3:0] kk;
    logic [3:0] n;
    kk = 4'(k);
`ifdef FFT_BITREV_EN
    n = {kk[0], kk[1], kk[2], kk[3]};
`else
    n = kk;
`endif
    return {18'(base + int'(n)), 18'd0};
  endfunction

  // FFT result with slot k holding base+k.
  function automatic logic [575:0] make_fft_out(input int base);
    logic [575:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[36*k +: 36] = 36'(base + k);
    end
    return v;
  endfunction

  // Streams 16 samples base..base+15 and ends on the first WAIT cycle.
  task automatic fill_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (sample_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fill_ready n=%0d got=%0b exp=1", i, sample_ready);
      end
      checks++;
      if (fft_start !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fill_start_low n=%0d got=%0b exp=0", i, fft_start);
      end
      sample_valid = 1'b1;
      sample_in    = 18'(base + i);
    end
    @(negedge clk);
    checks++;
    if (fft_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_rise got=%0b exp=1", fft_start);
    end
    checks++;
    if (sample_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wait_ready_low got=%0b exp=0", sample_ready);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (fft_in[36*k +: 36] !== exp_slot(base, k)) begin
        failures++;
        $display("[TB] FAIL slot%0d got=%0h exp=%0h", k, fft_in[36*k +: 36], exp_slot(base, k));
      end
    end
    sample_in = 18'h2AAAA;
  endtask

  // Holds off fft_done for delay more WAIT cycles, then presents the result.
  task automatic wait_done(input int delay, input int out_base);
    for (int j = 0; j < delay; j++) begin
      @(negedge clk);
      checks++;
      if (fft_start !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wait_start_high cyc=%0d got=%0b exp=1", j, fft_start);
      end
      checks++;
      if (bin_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wait_bin_valid cyc=%0d got=%0b exp=0", j, bin_valid);
      end
    end
    fft_done = 1'b1;
    fft_out  = make_fft_out(out_base);
  endtask

  // Drains 16 bins with bin_ready following pat (bit 0 first, repeating).
  task automatic drain_bins(input int base, input logic [3:0] pat);
    int exp_idx;
    int cyc;
    exp_idx = 0;
    cyc     = 0;
    @(negedge clk);
    fft_done = 1'b0;
    fft_out  = '1;
    checks++;
    if (fft_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_fall got=%0b exp=0", fft_start);
    end
    while (exp_idx < 16) begin
      checks++;
      if (bin_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bin_valid cyc=%0d got=%0b exp=1", cyc, bin_valid);
      end
      checks++;
      if (bin_idx !== 4'(exp_idx)) begin
        failures++;
        $display("[TB] FAIL bin_idx cyc=%0d got=%0d exp=%0d", cyc, bin_idx, exp_idx);
      end
      checks++;
      if (bin_out !== 36'(base + exp_idx)) begin
        failures++;
        $display("[TB] FAIL bin_out cyc=%0d got=%0d exp=%0d", cyc, bin_out, base + exp_idx);
      end
      checks++;
      if (bin_last !== logic'(exp_idx == 15)) begin
        failures++;
        $display("[TB] FAIL bin_last cyc=%0d got=%0b exp=%0b", cyc, bin_last, exp_idx == 15);
      end
      checks++;
      if (sample_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL drain_ready_low cyc=%0d got=%0b exp=0", cyc, sample_ready);
      end
      bin_ready = pat[cyc % 4];
      if (bin_ready) begin
        exp_idx++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (bin_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain_end_valid got=%0b exp=0", bin_valid);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_end_ready got=%0b exp=1", sample_ready);
    end
    checks++;
    if (bin_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain_end_last got=%0b exp=0", bin_last);
    end
    bin_ready    = 1'b0;
    sample_valid = 1'b0;
  endtask

  // Outputs are all zero under reset and the block is ready right after.
  task automatic test_reset;
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    fft_out      = '0;
    fft_done     = 1'b0;
    bin_ready    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sample_ready, fft_start, bin_valid, bin_last, fft_timeout} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%05b exp=00000",
               {sample_ready, fft_start, bin_valid, bin_last, fft_timeout});
    end
    checks++;
    if (fft_in !== '0) begin
      failures++;
      $display("[TB] FAIL reset_fft_in got=%0h exp=0", fft_in);
    end
    checks++;
    if ({bin_out, bin_idx} !== 40'd0) begin
      failures++;
      $display("[TB] FAIL reset_bin got=%0h exp=0", {bin_out, bin_idx});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_exit_ready got=%0b exp=1", sample_ready);
    end
  endtask

  // Ramp 0..15 lands in the expected slots and fft_start rises one cycle later.
  task automatic test_fill_ramp;
    fill_frame(0);
  endtask

  // fft_done five cycles after fft_start, bins 100..115 drained at full rate.
  task automatic test_done_drain;
    wait_done(5, 100);
    drain_bins(100, 4'b1111);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (fft_in[36*k +: 36] !== exp_slot(0, k)) begin
        failures++;
        $display("[TB] FAIL slot_hold%0d got=%0h exp=%0h", k, fft_in[36*k +: 36], exp_slot(0, k));
      end
    end
  endtask

  // bin_ready pattern 1,0,0,1: bins held while stalled, none skipped or repeated.
  task automatic test_ready_stall;
    fill_frame(200);
    wait_done(0, 300);
    drain_bins(300, 4'b1001);
  endtask

  // No fft_done: abort after 15 WAIT cycles, back to FILL, flag stays set.
  task automatic test_timeout;
    fill_frame(50);
    checks++;
    if (fft_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_early w=1 got=%0b exp=0", fft_timeout);
    end
    for (int w = 2; w <= 15; w++) begin
      @(negedge clk);
      checks++;
      if (fft_start !== 1'b1) begin
        failures++;
        $display("[TB] FAIL timeout_start_high w=%0d got=%0b exp=1", w, fft_start);
      end
      checks++;
      if (fft_timeout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL timeout_early w=%0d got=%0b exp=0", w, fft_timeout);
      end
    end
    @(negedge clk);
    checks++;
    if (fft_timeout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_flag got=%0b exp=1", fft_timeout);
    end
    checks++;
    if (fft_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_start_low got=%0b exp=0", fft_start);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_ready got=%0b exp=1", sample_ready);
    end
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fft_timeout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_sticky got=%0b exp=1", fft_timeout);
    end
  endtask

  // Reset after 7 samples clears everything; the next 16 samples make a full frame.
  task automatic test_reset_midframe;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 18'(40 + i);
    end
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({sample_ready, fft_start, bin_valid, bin_last, fft_timeout} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL midreset_flags got=%05b exp=00000",
               {sample_ready, fft_start, bin_valid, bin_last, fft_timeout});
    end
    checks++;
    if (fft_in !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_fft_in got=%0h exp=0", fft_in);
    end
    checks++;
    if ({bin_out, bin_idx} !== 40'd0) begin
      failures++;
      $display("[TB] FAIL midreset_bin got=%0h exp=0", {bin_out, bin_idx});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_exit_ready got=%0b exp=1", sample_ready);
    end
    fill_frame(600);
    wait_done(2, 700);
    drain_bins(700, 4'b1111);
  endtask

  // Scenario sequence and the final summary.
  initial begin
    test_reset;
    test_fill_ramp;
    test_done_drain;
    test_ready_stall;
    test_timeout;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
